// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: data width and the
// load/store size encodings carried in funct3.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_funct3_e;

endpackage

// File: rtl/load_extend.sv
// Selects the byte or half addressed within a word and sign/zero extends it
// according to funct3; unknown encodings return zero.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      byte_off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (byte_off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = '0;
    case (funct3_i)
      MEM_B:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      MEM_BU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      MEM_H:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      MEM_HU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      MEM_W:   data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with combinational loads, byte-enable stores,
// access checking and a sticky first-fault record.
module data_memory
  import riscv_pkg::*;
#(
  parameter int DataWidth = XLEN,
  parameter int Depth     = 1024,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 mem_rd_i,
  input  logic                 mem_wr_i,
  input  logic [2:0]           funct3_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 access_err_o,
  output logic                 fault_o,
  output logic [DataWidth-1:0] fault_addr_o
);

  localparam int Lanes = DataWidth / 8;

  logic [DataWidth-1:0] mem_q [Depth];

  logic [AddrWidth-1:0] word_idx;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] ext_data;
  logic                 misaligned;
  logic                 load_illegal;
  logic                 store_illegal;
  logic                 access_err;
  logic                 store_en;
  logic [Lanes-1:0]     byte_en;
  logic [DataWidth-1:0] store_data;

  logic                 fault_d, fault_q;
  logic [DataWidth-1:0] fault_addr_d, fault_addr_q;

  // Upper address bits are deliberately dropped so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[DataWidth-1:AddrWidth+2];

  assign word_idx = addr_i[AddrWidth+1:2];
  assign rd_word  = mem_q[word_idx];

  always_comb begin
    misaligned = 1'b0;
    case (funct3_i)
      MEM_H, MEM_HU: misaligned = addr_i[0];
      MEM_W:         misaligned = |addr_i[1:0];
      default:       misaligned = 1'b0;
    endcase
    load_illegal  = funct3_i inside {3'b011, 3'b110, 3'b111};
    store_illegal = !(funct3_i inside {MEM_B, MEM_H, MEM_W});
    access_err    = !rst_i &&
                    ((mem_rd_i && (misaligned || load_illegal)) ||
                     (mem_wr_i && (misaligned || store_illegal)));
    store_en      = !rst_i && mem_wr_i && !access_err;
  end

  // Narrow stores replicate their data across the word; byte enables pick the lanes.
  always_comb begin
    byte_en    = '0;
    store_data = '0;
    case (funct3_i)
      MEM_B: begin
        byte_en    = Lanes'(1) << addr_i[1:0];
        store_data = {Lanes{wr_data_i[7:0]}};
      end
      MEM_H: begin
        byte_en    = addr_i[1] ? 4'b1100 : 4'b0011;
        store_data = {(Lanes/2){wr_data_i[15:0]}};
      end
      MEM_W: begin
        byte_en    = '1;
        store_data = wr_data_i;
      end
      default: begin
        byte_en    = '0;
        store_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (store_en) begin
      for (int b = 0; b < Lanes; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  load_extend u_load_extend (
    .word_i     (rd_word),
    .byte_off_i (addr_i[1:0]),
    .funct3_i   (funct3_i),
    .data_o     (ext_data)
  );

  assign rd_data_o    = (!rst_i && mem_rd_i && !access_err) ? ext_data : '0;
  assign access_err_o = access_err;

  // Only the first fault since reset is recorded.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (access_err && !fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;

endmodule
